// File: rtl/vs_sdi_streamer.sv
// vs_sdi_streamer: streams bytes to a VS10xx-style SDI port (XDCS/SCK/SI),
// mode 0, MSB first, in DREQ-qualified bursts of up to BURST_LEN bytes.
// A burst ends after BURST_LEN bytes or when no byte is offered in LOAD.
// XDCS is then held high for GAP_CYC cycles before DREQ is looked at again.
// Optional feature: define VS_SDI_BYTECNT_EN to add the 16-bit o_byte_cnt
// output counting accepted bytes.
module vs_sdi_streamer #(
  parameter int CLK_DIV   = 4,
  parameter int BURST_LEN = 32,
  parameter int GAP_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_DREQ,
  output logic        o_SI,
  output logic        o_SCK,
  output logic        o_XDCS,
  output logic        o_busy
`ifdef VS_SDI_BYTECNT_EN
  ,
  output logic [15:0] o_byte_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Terminal counts, sized to the counters that compare against them.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [5:0] BURST_LAST = 6'(BURST_LEN);

  state_t      state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;   // bit 7 is always the bit on SI
  logic [2:0]  bit_reg,   bit_next;     // index of the bit currently on SI
  logic [7:0]  div_reg,   div_next;     // cycles spent in current SCK phase
  logic        sck_reg,   sck_next;
  logic [5:0]  burst_reg, burst_next;   // bytes captured in this burst
  logic [7:0]  gap_reg,   gap_next;     // cycles spent in GAP

  // State and datapath registers; reset aborts any byte in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      sck_reg   <= 1'b0;
      burst_reg <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      div_reg   <= div_next;
      sck_reg   <= sck_next;
      burst_reg <= burst_next;
      gap_reg   <= gap_next;
    end
  end

  // Next-state and datapath logic: LOAD captures, SHIFT runs SCK phases,
  // GAP times the chip-select high interval.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    div_next   = div_reg;
    sck_next   = sck_reg;
    burst_next = burst_reg;
    gap_next   = gap_reg;

    case (state_reg)
      ST_IDLE: begin
        // DREQ high promises room for a whole burst, so it is only
        // sampled here and never during a burst.
        if (i_valid && i_DREQ) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        div_next = '0;
        bit_next = '0;
        sck_next = 1'b0;
        if (i_valid) begin
          shift_next = i_byte;
          burst_next = burst_reg + 6'd1;
          state_next = ST_SHIFT;
        end else begin
          // Upstream ran dry: close the burst early.
          burst_next = '0;
          gap_next   = '0;
          state_next = ST_GAP;
        end
      end

      ST_SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!sck_reg) begin
            sck_next = 1'b1;
          end else begin
            // Falling edge: advance SI, or finish the byte with SCK low.
            sck_next = 1'b0;
            if (bit_reg == 3'd7) begin
              if (burst_reg == BURST_LAST) begin
                burst_next = '0;
                gap_next   = '0;
                state_next = ST_GAP;
              end else begin
                state_next = ST_LOAD;
              end
            end else begin
              bit_next   = bit_reg + 3'd1;
              shift_next = {shift_reg[6:0], 1'b0};
            end
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          gap_next   = '0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and chip select are pure decodes of the state register.
  always_comb begin
    o_ready = (state_reg == ST_LOAD);
    o_XDCS  = !((state_reg == ST_LOAD) || (state_reg == ST_SHIFT));
    o_busy  = (state_reg != ST_IDLE);
    o_SCK   = sck_reg;
    o_SI    = shift_reg[7];
  end

`ifdef VS_SDI_BYTECNT_EN
  logic [15:0] byte_cnt_reg;

  // Free-running count of accepted bytes, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg <= '0;
    end else if ((state_reg == ST_LOAD) && i_valid) begin
      byte_cnt_reg <= byte_cnt_reg + 16'd1;
    end
  end

  assign o_byte_cnt = byte_cnt_reg;
`endif

endmodule

// File: tb/tb_vs_sdi_streamer.sv
// Testbench for vs_sdi_streamer (default parameters). Recovers bytes from
// SCK/SI and compares them, the burst sizes and the gap lengths against
// values derived from the bytes the bench offered.
module tb_vs_sdi_streamer;

  localparam int CLK_DIV   = 4;
  localparam int BURST_LEN = 32;
  localparam int GAP_CYC   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_byte;
  logic       i_valid;
  logic       o_ready;
  logic       i_DREQ;
  logic       o_SI;
  logic       o_SCK;
  logic       o_XDCS;
  logic       o_busy;
`ifdef VS_SDI_BYTECNT_EN
  logic [15:0] o_byte_cnt;
`endif

  vs_sdi_streamer #(
    .CLK_DIV  (CLK_DIV),
    .BURST_LEN(BURST_LEN),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_byte (i_byte),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_DREQ (i_DREQ),
    .o_SI   (o_SI),
    .o_SCK  (o_SCK),
    .o_XDCS (o_XDCS),
    .o_busy (o_busy)
`ifdef VS_SDI_BYTECNT_EN
    ,
    .o_byte_cnt(o_byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source side and expected stream.
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit         feed_en  = 1'b0;
  bit         stall_en = 1'b0;

  // Observed side.
  logic [7:0] rx_q[$];
  int         burst_q[$];
  int         gap_q[$];
  logic [7:0] rx_shift    = '0;
  int         rx_bits     = 0;
  int         sck_rises   = 0;
  int         shift_cyc   = 0;
  int         burst_bytes = 0;
  int         gap_run     = 0;
  logic       prev_sck    = 1'b0;
  logic       prev_xdcs   = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    i_valid = feed_en && (src_q.size() > 0) && (!stall_en || ($urandom_range(0, 3) != 0));
    i_byte  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  // One clock: observe at the falling edge, then re-drive inputs after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (o_SCK && !prev_sck) begin
      check("xdcs_low_at_sck_rise", o_XDCS, 1'b0);
      sck_rises++;
      rx_shift = {rx_shift[6:0], o_SI};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_q.push_back(rx_shift);
        rx_bits = 0;
        burst_bytes++;
      end
    end
    if (!o_XDCS && !o_ready) shift_cyc++;
    if (o_XDCS && !prev_xdcs) begin
      burst_q.push_back(burst_bytes);
      burst_bytes = 0;
    end
    if (o_busy && o_XDCS) begin
      gap_run++;
    end else if (gap_run != 0) begin
      gap_q.push_back(gap_run);
      gap_run = 0;
    end
    if (i_valid && o_ready && rst_n) void'(src_q.pop_front());
    prev_sck  = o_SCK;
    prev_xdcs = o_XDCS;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_model();
    rx_q.delete();
    exp_q.delete();
    burst_q.delete();
    gap_q.delete();
    sck_rises = 0;
    shift_cyc = 0;
  endtask

  task automatic push_rand(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 20000) begin
      tick();
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (o_busy && k < 5000) begin
      tick();
      k++;
    end
    check(tag, o_busy, 1'b0);
    tick();
    tick();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check({tag, "_byte"}, rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mx;
    int sum;

    // Reset state.
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_byte  = 8'h00;
    i_DREQ  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", o_SCK, 1'b0);
    check("rst_si", o_SI, 1'b0);
    check("rst_xdcs", o_XDCS, 1'b1);
    check("rst_ready", o_ready, 1'b0);
    check("rst_busy", o_busy, 1'b0);
`ifdef VS_SDI_BYTECNT_EN
    check("rst_byte_cnt", o_byte_cnt, 16'h0000);
`endif
    rst_n = 1'b1;
    tick();

    // DREQ low blocks everything; then latency and single byte 0xA5.
    clear_model();
    src_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    feed_en = 1'b1;
    drive();
    repeat (10) tick();
    check("dreq0_ready", o_ready, 1'b0);
    check("dreq0_xdcs", o_XDCS, 1'b1);
    check("dreq0_sck_rises", sck_rises, 0);
    i_DREQ = 1'b1;
    tick();
    check("lat_ready_n1", o_ready, 1'b1);
    check("lat_xdcs_n1", o_XDCS, 1'b0);
    tick();
    check("lat_si_n2", o_SI, 1'b1);
    check("lat_sck_n2", o_SCK, 1'b0);
    n = 0;
    while (!o_SCK && n < 50) begin
      tick();
      n++;
    end
    check("lat_first_rise", n, CLK_DIV);
    wait_idle("a5_idle");
    compare_stream("a5");
    check("a5_shift_cycles", shift_cyc, 16 * CLK_DIV);
    check("a5_sck_rises", sck_rises, 8);
    check("a5_burst_size", burst_q.size() > 0 ? burst_q[0] : -1, 1);
    check("a5_gap_len", gap_q.size() > 0 ? gap_q[0] : -1, GAP_CYC);

    // 40 bytes continuous: one full burst, gap, remainder.
    clear_model();
    push_rand(40);
    wait_rx(40, "s40_rx");
    wait_idle("s40_idle");
    compare_stream("s40");
    check("s40_sck_rises", sck_rises, 320);
    check("s40_bursts", burst_q.size(), 2);
    check("s40_burst0", burst_q.size() > 0 ? burst_q[0] : -1, BURST_LEN);
    check("s40_burst1", burst_q.size() > 1 ? burst_q[1] : -1, 40 - BURST_LEN);
    check("s40_gap0", gap_q.size() > 0 ? gap_q[0] : -1, GAP_CYC);

    // DREQ dropped after byte 3: burst still completes, then waits for DREQ.
    clear_model();
    push_rand(40);
    wait_rx(3, "dq_rx3");
    i_DREQ = 1'b0;
    wait_idle("dq_idle1");
    check("dq_first_burst", rx_q.size(), BURST_LEN);
    repeat (50) tick();
    check("dq_hold_sck_rises", sck_rises, 8 * BURST_LEN);
    check("dq_hold_busy", o_busy, 1'b0);
    check("dq_hold_xdcs", o_XDCS, 1'b1);
    i_DREQ = 1'b1;
    wait_rx(40, "dq_rx40");
    wait_idle("dq_idle2");
    compare_stream("dq");
    check("dq_burst1", burst_q.size() > 1 ? burst_q[1] : -1, 40 - BURST_LEN);

    // Upstream runs dry after byte 5; next burst starts when data returns.
    clear_model();
    push_rand(5);
    wait_rx(5, "dry_rx5");
    wait_idle("dry_idle1");
    check("dry_burst0", burst_q.size() > 0 ? burst_q[0] : -1, 5);
    check("dry_gap0", gap_q.size() > 0 ? gap_q[0] : -1, GAP_CYC);
    push_rand(7);
    wait_rx(12, "dry_rx12");
    wait_idle("dry_idle2");
    compare_stream("dry");
    check("dry_burst1", burst_q.size() > 1 ? burst_q[1] : -1, 7);

    // Random valid stalls: order kept, no burst exceeds BURST_LEN.
    clear_model();
    stall_en = 1'b1;
    push_rand(30);
    wait_rx(30, "stall_rx");
    stall_en = 1'b0;
    wait_idle("stall_idle");
    compare_stream("stall");
    mx  = 0;
    sum = 0;
    foreach (burst_q[i]) begin
      sum += burst_q[i];
      if (burst_q[i] > mx) mx = burst_q[i];
    end
    check("stall_max_burst_ok", mx <= BURST_LEN, 1'b1);
    check("stall_sum", sum, 30);

    // Reset mid-byte 3: immediate reset values, byte 3 is dropped.
    clear_model();
    push_rand(10);
    n = 0;
    while (!(rx_q.size() == 2 && rx_bits == 3) && n < 5000) begin
      tick();
      n++;
    end
    check("rr_reached_mid_byte", rx_bits, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_sck", o_SCK, 1'b0);
    check("rr_si", o_SI, 1'b0);
    check("rr_xdcs", o_XDCS, 1'b1);
    check("rr_ready", o_ready, 1'b0);
    check("rr_busy", o_busy, 1'b0);
`ifdef VS_SDI_BYTECNT_EN
    check("rr_byte_cnt", o_byte_cnt, 16'h0000);
`endif
    rx_bits  = 0;
    rx_shift = '0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete(2);
    wait_rx(9, "rr_rx");
    wait_idle("rr_idle");
    compare_stream("rr");
`ifdef VS_SDI_BYTECNT_EN
    check("rr_byte_cnt_after", o_byte_cnt, 16'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
